// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues single-outstanding
// requests to instruction memory and buffers PC-tagged responses for decode.
module fetch_queue #(
    parameter int D     = 12,
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [D-1:0] start_addr,
    output logic         imem_req,
    output logic [D-1:0] imem_addr,
    input  logic         imem_rvalid,
    input  logic [W-1:0] imem_rdata,
    output logic         instr_valid,
    output logic [W-1:0] instr,
    output logic [D-1:0] instr_pc,
    input  logic         instr_ready,
    input  logic         absjump,
    input  logic         reljump,
    input  logic [D-1:0] target,
    output logic         done
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t         r_state, w_next;
    logic [D-1:0]   r_fetch_pc, r_req_addr;
    logic           r_out, r_stale;
    logic [W-1:0]   r_q_instr [DEPTH];
    logic [D-1:0]   r_q_pc    [DEPTH];
    logic [AW-1:0]  r_head, r_tail;
    logic [CW-1:0]  r_count;

    logic           w_pop, w_redirect, w_resp, w_push, w_pc_all1, w_room, w_can_issue;
    logic [D-1:0]   w_redir_pc;

    assign w_pop       = instr_valid & instr_ready;
    assign w_redirect  = w_pop & (absjump | reljump);
    assign w_resp      = imem_rvalid & r_out;
    // Responses landing in the redirect cycle belong to the old path.
    assign w_push      = w_resp & ~r_stale & ~w_redirect;
    assign w_pc_all1   = &r_fetch_pc;
    // An issued request reserves a slot: entries held + this request must fit.
    assign w_room      = (r_count + CW'(1)) < CW'(DEPTH);
    assign w_can_issue = ~w_pc_all1 & (~r_out | imem_rvalid) & w_room & ~w_redirect;
    assign w_redir_pc  = absjump ? target : (instr_pc + target);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_pc_all1 && !r_out && r_count == '0) w_next = S_HALT;
            S_HALT:  if (start) w_next = S_RUN;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        done     = 1'b0;
        if (r_state == S_RUN)  imem_req = w_can_issue;
        if (r_state == S_HALT) done     = 1'b1;
    end

    assign imem_addr   = r_fetch_pc;
    assign instr_valid = (r_count != '0);
    assign instr       = r_q_instr[r_head];
    assign instr_pc    = r_q_pc[r_head];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= '0;
            r_req_addr <= '0;
            r_out      <= 1'b0;
            r_stale    <= 1'b0;
        end else begin
            if ((r_state == S_IDLE || r_state == S_HALT) && start)
                r_fetch_pc <= start_addr;
            else if (w_redirect)
                r_fetch_pc <= w_redir_pc;
            else if (imem_req)
                r_fetch_pc <= r_fetch_pc + D'(1);

            if (imem_req)    r_req_addr <= r_fetch_pc;

            if (imem_req)    r_out <= 1'b1;
            else if (w_resp) r_out <= 1'b0;

            if (w_resp && r_stale)
                r_stale <= 1'b0;
            else if (w_redirect && r_out && !imem_rvalid)
                r_stale <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_redirect) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + AW'(1);
            if (w_pop)  r_head <= r_head + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage needs no reset: entries are only visible through r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_tail] <= imem_rdata;
            r_q_pc[r_tail]    <= r_req_addr;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed scenarios push expected PCs,
// a negedge monitor pops them on every consumed instruction.
module tb_fetch_queue;
    localparam int D = 12, W = 9, DEPTH = 4;

    logic         clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [D-1:0] start_addr = '0, target = '0;
    logic         imem_rvalid = 1'b0, instr_ready = 1'b0, absjump = 1'b0, reljump = 1'b0;
    logic [W-1:0] imem_rdata = '0;
    logic         imem_req, instr_valid, done;
    logic [D-1:0] imem_addr, instr_pc;
    logic [W-1:0] instr;

    fetch_queue #(.D(D), .W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .instr_ready(instr_ready), .absjump(absjump),
        .reljump(reljump), .target(target), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, pops = 0, lat = 1, m_cnt = 0;
    logic         m_busy = 1'b0;
    logic [D-1:0] m_addr = '0;
    logic [D-1:0] exp_q[$];
    logic [D-1:0] req_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Instruction memory: fixed latency per request, rdata = addr[8:0].
    always @(posedge clk) begin
        imem_rvalid <= 1'b0;
        if (m_busy) begin
            if (m_cnt <= 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= m_addr[8:0];
                m_busy      <= 1'b0;
            end else m_cnt <= m_cnt - 1;
        end
        if (imem_req) begin
            if (lat <= 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= imem_addr[8:0];
            end else begin
                m_busy <= 1'b1;
                m_cnt  <= lat - 1;
                m_addr <= imem_addr;
            end
        end
    end

    // Monitor: log requests, score every consumed instruction.
    always @(negedge clk) begin
        if (reset) begin
            if (imem_req) req_log.push_back(imem_addr);
            if (instr_valid && instr_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 32'(instr_pc), 32'hFFFF_FFFF);
                end else begin
                    logic [D-1:0] e;
                    e = exp_q.pop_front();
                    check("pop_pc", 32'(instr_pc), 32'(e));
                    check("pop_instr", 32'(instr), 32'(e[8:0]));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        instr_ready = 0; absjump = 0; reljump = 0; start = 0;
        reset = 0;
        exp_q.delete();
        tick(2);
        reset = 1;
        tick(5);
        req_log.delete();
        pops = 0;
    endtask

    task automatic do_start(input logic [D-1:0] a);
        start_addr = a; start = 1;
        tick(1);
        start = 0;
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        int k = 0;
        while (pops < n && k < budget) begin tick(1); k++; end
        check(name, 32'(pops >= n), 32'd1);
    endtask

    task automatic wait_valid(input int budget, input string name);
        int k = 0;
        while (!instr_valid && k < budget) begin tick(1); k++; end
        check(name, 32'(instr_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_req, t_vld, nreq, idx;
        logic any_req, any_vld, saw_rv;

        // Reset state
        tick(1);
        check("rst_imem_req", 32'(imem_req), 0);
        check("rst_instr_valid", 32'(instr_valid), 0);
        check("rst_done", 32'(done), 0);
        do_reset();

        // Streaming, 1-cycle memory
        lat = 1; instr_ready = 1;
        for (int i = 0; i < 40; i++) exp_q.push_back(D'(i));
        do_start(12'h000);
        t_req = -1; t_vld = -1; nreq = 0;
        for (int k = 0; k < 20; k++) begin
            if (t_req < 0 && imem_req) t_req = k;
            if (t_vld < 0 && instr_valid) t_vld = k;
            if (imem_req) nreq++;
            tick(1);
        end
        check("stream_latency", 32'(t_vld - t_req), 2);
        check("stream_req_every_cycle", 32'(nreq), 20);
        wait_pops(16, 10, "stream_pops");
        do_reset();

        // Back-pressure
        lat = 1;
        do_start(12'h000);
        tick(12);
        check("bp_req_count", 32'(req_log.size()), 4);
        for (int i = 0; i < 4; i++)
            if (i < req_log.size()) check("bp_req_addr", 32'(req_log[i]), 32'(i));
        check("bp_head_valid", 32'(instr_valid), 1);
        for (int i = 0; i < 10; i++) exp_q.push_back(D'(i));
        instr_ready = 1;
        wait_pops(10, 40, "bp_drain");
        instr_ready = 0;
        if (req_log.size() > 4) check("bp_resume_addr", 32'(req_log[4]), 32'h004);
        else check("bp_resume_missing", 32'(req_log.size()), 5);
        do_reset();

        // Relative redirect with a 3-cycle request in flight
        lat = 3;
        exp_q.push_back(12'h010);
        do_start(12'h010);
        wait_valid(20, "rel_first_valid");
        check("rel_head_pc", 32'(instr_pc), 32'h010);
        check("rel_req_in_flight", 32'(m_busy), 1);
        idx = req_log.size();
        instr_ready = 1; reljump = 1; target = 12'hFFE;
        #1;
        check("rel_no_req_redirect_cycle", 32'(imem_req), 0);
        tick(1);
        instr_ready = 0; reljump = 0;
        check("rel_flushed", 32'(instr_valid), 0);
        exp_q.push_back(12'h00E); exp_q.push_back(12'h00F);
        instr_ready = 1;
        wait_pops(3, 60, "rel_pops");
        instr_ready = 0;
        if (req_log.size() > idx) check("rel_next_req", 32'(req_log[idx]), 32'h00E);
        else check("rel_next_req_missing", 32'(req_log.size()), 32'(idx + 1));
        do_reset();

        // Absolute redirect wins over relative
        lat = 1;
        exp_q.push_back(12'h040);
        do_start(12'h040);
        wait_valid(20, "abs_first_valid");
        check("abs_head_pc", 32'(instr_pc), 32'h040);
        idx = req_log.size();
        instr_ready = 1; absjump = 1; reljump = 1; target = 12'h123;
        #1;
        check("abs_no_req_redirect_cycle", 32'(imem_req), 0);
        tick(1);
        absjump = 0; reljump = 0;
        exp_q.push_back(12'h123); exp_q.push_back(12'h124);
        wait_pops(3, 40, "abs_pops");
        instr_ready = 0;
        if (req_log.size() > idx) check("abs_next_req", 32'(req_log[idx]), 32'h123);
        else check("abs_next_req_missing", 32'(req_log.size()), 32'(idx + 1));
        do_reset();

        // Halt at the top of the address space, then restart
        lat = 1; instr_ready = 1;
        exp_q.push_back(12'hFFD); exp_q.push_back(12'hFFE);
        do_start(12'hFFD);
        for (int k = 0; k < 30 && !done; k++) tick(1);
        check("halt_done", 32'(done), 1);
        check("halt_req_count", 32'(req_log.size()), 2);
        if (req_log.size() >= 2) begin
            check("halt_req0", 32'(req_log[0]), 32'hFFD);
            check("halt_req1", 32'(req_log[1]), 32'hFFE);
        end
        check("halt_pops", 32'(pops), 2);
        for (int i = 0; i < 3; i++) exp_q.push_back(D'(i));
        do_start(12'h000);
        check("restart_done_clear", 32'(done), 0);
        wait_pops(5, 40, "restart_pops");
        instr_ready = 0;
        if (req_log.size() > 2) check("restart_first_req", 32'(req_log[2]), 32'h000);
        else check("restart_req_missing", 32'(req_log.size()), 3);
        do_reset();

        // Asynchronous reset mid-burst with a late response
        lat = 3; instr_ready = 1;
        for (int i = 0; i < 10; i++) exp_q.push_back(D'(i));
        do_start(12'h000);
        tick(8);
        for (int k = 0; k < 10 && !m_busy; k++) tick(1);
        check("async_pre_busy", 32'(m_busy), 1);
        check("async_pre_pops", 32'(pops >= 1), 1);
        #2;
        reset = 0;
        exp_q.delete();
        #1;
        check("async_instr_valid", 32'(instr_valid), 0);
        check("async_imem_req", 32'(imem_req), 0);
        check("async_done", 32'(done), 0);
        #2;
        reset = 1;
        any_req = 0; any_vld = 0; saw_rv = 0;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            any_req |= imem_req; any_vld |= instr_valid; saw_rv |= imem_rvalid;
        end
        check("async_late_rvalid_seen", 32'(saw_rv), 1);
        check("async_no_push", 32'(any_vld), 0);
        check("async_idle_no_req", 32'(any_req), 0);
        check("async_idle_not_done", 32'(done), 0);
        instr_ready = 0;
        req_log.delete();
        do_start(12'h020);
        tick(2);
        if (req_log.size() > 0) check("async_restart_addr", 32'(req_log[0]), 32'h020);
        else check("async_restart_missing", 32'(req_log.size()), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
